sequenciador_busca: RTL
=======================

Name: sequenciador_busca

Overview:
Fetch sequencer that owns the program counter and drives the instruction-memory request/acknowledge handshake. It presents each fetched instruction, tagged with its PC, to the decode stage through a valid/ready handshake. It accepts branch/jump redirects from execute and discards any in-flight fetch that a redirect makes stale. It sits between the instruction memory and decode and replaces free-running PC increment with flow-controlled sequencing.

Parameters:
PC_STEP, 1, PC increment per sequential fetch (word addressing).
RESET_VECTOR, 0, PC value loaded on reset.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
habilita  input  1  1 = fetch enabled; 0 = stop issuing new fetches
mem_req  output  1  instruction-memory request
mem_endereco  output  64  registered fetch address; stable while mem_req=1
mem_ack  input  1  memory response valid for the current request (single-cycle pulse)
mem_dado  input  32  instruction word, valid when mem_ack=1
desvio_valido  input  1  redirect pulse from execute
desvio_alvo  input  64  redirect target PC
instr_valida  output  1  instruction available to decode
instr_pronta  input  1  decode accepts the instruction
instr  output  32  held instruction word
instr_pc  output  64  PC of the held instruction
pc  output  64  next PC to fetch (architectural PC)

Behaviour:
- Reset, asynchronous, with priority over everything:
  - state=OCIOSO; pc=RESET_VECTOR; mem_endereco=RESET_VECTOR.
  - mem_req=0, instr_valida=0, instr=0, instr_pc=0.
  - An in-flight fetch is abandoned; a late mem_ack after reset is ignored in OCIOSO.
- States: OCIOSO, BUSCA, ENTREGA, DESCARTA.
  - mem_req=1 in BUSCA and DESCARTA; otherwise 0.
  - instr_valida=1 only in ENTREGA.
- OCIOSO:
  - habilita=1: mem_endereco<=pc, go to BUSCA.
  - desvio_valido=1: pc<=desvio_alvo. Redirect has priority; if habilita=1 in the same cycle, mem_endereco<=desvio_alvo.
- BUSCA:
  - mem_req held at 1 with mem_endereco unchanged until mem_ack.
  - mem_ack=1 and no redirect: instr<=mem_dado; instr_pc<=mem_endereco; pc<=mem_endereco+PC_STEP; go to ENTREGA.
  - desvio_valido=1 with mem_ack=1 in the same cycle: discard the data; pc<=desvio_alvo; mem_endereco<=desvio_alvo; stay in BUSCA. The new request is visible on the next cycle.
  - desvio_valido=1 without mem_ack: pc<=desvio_alvo; go to DESCARTA.
- DESCARTA:
  - Keeps mem_req=1 with the old mem_endereco, since memory requires req held until ack.
  - On mem_ack, data is dropped, then:
    - habilita=1: mem_endereco<=pc, go to BUSCA.
    - habilita=0: go to OCIOSO.
  - A further redirect while in DESCARTA overwrites pc; the last redirect wins.
- ENTREGA:
  - instr, instr_pc held stable while instr_valida=1 and instr_pronta=0.
  - instr_pronta=1: handshake completes that cycle.
    - habilita=1: mem_endereco<=pc, go to BUSCA (back-to-back, one fetch per ack+1 cycles minimum).
    - habilita=0: go to OCIOSO.
  - desvio_valido=1, with priority over instr_pronta: instr_valida drops next cycle (instruction squashed); pc<=desvio_alvo; then:
    - habilita=1: mem_endereco<=desvio_alvo, go to BUSCA.
    - habilita=0: go to OCIOSO.
- habilita=0 never aborts an outstanding request or a held instruction; it only prevents the next issue.
- Arithmetic: pc+PC_STEP is modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFF + 1 wraps to 0 with no flag.
- mem_ack outside BUSCA/DESCARTA is ignored.
- Latency: mem_ack at cycle n gives instr_valida=1 at cycle n+1.

Optional Feature:
SEQ_CONTADORES_EN
- Defined: adds outputs num_entregues[31:0] and num_descartes[31:0], both reset to 0.
  - num_entregues increments on each completed instr_valida&instr_pronta handshake.
  - num_descartes increments on each dropped response (BUSCA ack+redirect, DESCARTA ack) and on each squash in ENTREGA.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
1. Reset with RESET_VECTOR=0, habilita=1, memory acks 2 cycles after req, instr_pronta=1 -> fetch addresses 0,1,2,3; instr_pc matches; pc=4 after four deliveries.
2. Hold instr_pronta=0 for 5 cycles in ENTREGA -> instr/instr_pc unchanged, mem_req=0, no new fetch; release -> next fetch at instr_pc+1.
3. desvio_valido with alvo=0x100 one cycle before mem_ack in BUSCA -> DESCARTA; old ack dropped, no instr_valida; next mem_endereco=0x100.
4. desvio_valido and mem_ack in the same cycle (alvo=0x40) -> data discarded; next cycle mem_req=1, mem_endereco=0x40.
5. Redirect alvo=64'hFFFF_FFFF_FFFF_FFFF, fetch completes -> instr_pc=all-ones, pc wraps to 0, next fetch at 0.
6. Assert reset asynchronously mid-BUSCA, then pulse mem_ack after release -> outputs at reset values immediately; stray ack ignored; fetch restarts at RESET_VECTOR. With SEQ_CONTADORES_EN, counters read 0.

Source files
------------

// File: rtl/sequenciador_busca.sv
// Fetch sequencer: owns the PC, drives the imem req/ack handshake, feeds decode.
// Optional per-event counters are built when SEQ_CONTADORES_EN is defined.
module sequenciador_busca #(
    parameter logic [63:0] PC_STEP      = 64'd1,
    parameter logic [63:0] RESET_VECTOR = 64'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        habilita,
    output logic        mem_req,
    output logic [63:0] mem_endereco,
    input  logic        mem_ack,
    input  logic [31:0] mem_dado,
    input  logic        desvio_valido,
    input  logic [63:0] desvio_alvo,
    output logic        instr_valida,
    input  logic        instr_pronta,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic [63:0] pc
`ifdef SEQ_CONTADORES_EN
    ,
    output logic [31:0] num_entregues,
    output logic [31:0] num_descartes
`endif
);

    typedef enum logic [1:0] {
        OCIOSO,
        BUSCA,
        ENTREGA,
        DESCARTA
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] end_q, end_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] ipc_q, ipc_d;

    // State and datapath registers; reset abandons any fetch in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            pc_q     <= RESET_VECTOR;
            end_q    <= RESET_VECTOR;
            instr_q  <= 32'd0;
            ipc_q    <= 64'd0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            end_q    <= end_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
        end
    end

    // Next-state logic; redirects always win over delivery or new issue.
    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        end_d    = end_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        unique case (estado_q)
            OCIOSO: begin
                if (desvio_valido) pc_d = desvio_alvo;
                if (habilita) begin
                    end_d    = desvio_valido ? desvio_alvo : pc_q;
                    estado_d = BUSCA;
                end
            end
            BUSCA: begin
                if (mem_ack && desvio_valido) begin
                    pc_d  = desvio_alvo;
                    end_d = desvio_alvo;
                end else if (mem_ack) begin
                    instr_d  = mem_dado;
                    ipc_d    = end_q;
                    pc_d     = end_q + PC_STEP;
                    estado_d = ENTREGA;
                end else if (desvio_valido) begin
                    pc_d     = desvio_alvo;
                    estado_d = DESCARTA;
                end
            end
            DESCARTA: begin
                // Memory still owes the stale response; keep req until ack.
                if (desvio_valido) pc_d = desvio_alvo;
                if (mem_ack) begin
                    if (habilita) begin
                        end_d    = pc_d;
                        estado_d = BUSCA;
                    end else begin
                        estado_d = OCIOSO;
                    end
                end
            end
            ENTREGA: begin
                if (desvio_valido) begin
                    pc_d = desvio_alvo;
                    if (habilita) begin
                        end_d    = desvio_alvo;
                        estado_d = BUSCA;
                    end else begin
                        estado_d = OCIOSO;
                    end
                end else if (instr_pronta) begin
                    if (habilita) begin
                        end_d    = pc_q;
                        estado_d = BUSCA;
                    end else begin
                        estado_d = OCIOSO;
                    end
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    assign mem_req      = (estado_q == BUSCA) || (estado_q == DESCARTA);
    assign instr_valida = (estado_q == ENTREGA);
    assign mem_endereco = end_q;
    assign instr        = instr_q;
    assign instr_pc     = ipc_q;
    assign pc           = pc_q;

`ifdef SEQ_CONTADORES_EN
    logic        ev_entregue;
    logic        ev_descarte;
    logic [31:0] ent_q, desc_q;

    // Event decode: completed handshakes, dropped responses and squashes.
    always_comb begin
        ev_entregue = (estado_q == ENTREGA) && instr_pronta && !desvio_valido;
        ev_descarte = ((estado_q == BUSCA) && mem_ack && desvio_valido)
                   || ((estado_q == DESCARTA) && mem_ack)
                   || ((estado_q == ENTREGA) && desvio_valido);
    end

    // Saturating event counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent_q  <= 32'd0;
            desc_q <= 32'd0;
        end else begin
            if (ev_entregue && (ent_q != 32'hFFFF_FFFF)) ent_q <= ent_q + 32'd1;
            if (ev_descarte && (desc_q != 32'hFFFF_FFFF)) desc_q <= desc_q + 32'd1;
        end
    end

    assign num_entregues = ent_q;
    assign num_descartes = desc_q;
`endif

endmodule
